// File: rtl/median_partition_if.sv
// Token-stream bundle around median_partition_actor: five input FIFO read
// ports (pixel plus four header tokens) and six output FIFO write ports.
// The actor side connects through the slave modport, the FIFO/environment
// side through the master modport.
interface median_partition_if #(
  parameter int BUFF_SIZE_BIT = 4
);
  // Input streams (FIFO read side)
  logic [7:0]               in_px;
  logic                     in_px_rd;
  logic                     in_px_empty;
  logic [7:0]               in_pivot;
  logic                     in_pivot_rd;
  logic                     in_pivot_empty;
  logic [BUFF_SIZE_BIT-1:0] in_buff_size;
  logic                     in_buff_size_rd;
  logic                     in_buff_size_empty;
  logic [BUFF_SIZE_BIT-1:0] in_median_pos;
  logic                     in_median_pos_rd;
  logic                     in_median_pos_empty;
  logic [7:0]               in_second_median_value;
  logic                     in_second_median_value_rd;
  logic                     in_second_median_value_empty;

  // Output streams (FIFO write side)
  logic [7:0]               out_px;
  logic                     out_px_wr;
  logic                     out_px_full;
  logic [7:0]               out_pivot;
  logic                     out_pivot_wr;
  logic                     out_pivot_full;
  logic [BUFF_SIZE_BIT-1:0] out_buff_size;
  logic                     out_buff_size_wr;
  logic                     out_buff_size_full;
  logic [BUFF_SIZE_BIT-1:0] out_median_pos;
  logic                     out_median_pos_wr;
  logic                     out_median_pos_full;
  logic [7:0]               out_second_median_value;
  logic                     out_second_median_value_wr;
  logic                     out_second_median_value_full;
  logic [7:0]               out_median;
  logic                     out_median_wr;
  logic                     out_median_full;

  // Environment side: feeds input FIFOs, absorbs output tokens
  modport master (
    output in_px, in_px_empty, input in_px_rd,
    output in_pivot, in_pivot_empty, input in_pivot_rd,
    output in_buff_size, in_buff_size_empty, input in_buff_size_rd,
    output in_median_pos, in_median_pos_empty, input in_median_pos_rd,
    output in_second_median_value, in_second_median_value_empty,
    input  in_second_median_value_rd,
    input  out_px, out_px_wr, output out_px_full,
    input  out_pivot, out_pivot_wr, output out_pivot_full,
    input  out_buff_size, out_buff_size_wr, output out_buff_size_full,
    input  out_median_pos, out_median_pos_wr, output out_median_pos_full,
    input  out_second_median_value, out_second_median_value_wr,
    output out_second_median_value_full,
    input  out_median, out_median_wr, output out_median_full
  );

  // Actor side
  modport slave (
    input  in_px, in_px_empty, output in_px_rd,
    input  in_pivot, in_pivot_empty, output in_pivot_rd,
    input  in_buff_size, in_buff_size_empty, output in_buff_size_rd,
    input  in_median_pos, in_median_pos_empty, output in_median_pos_rd,
    input  in_second_median_value, in_second_median_value_empty,
    output in_second_median_value_rd,
    output out_px, out_px_wr, input out_px_full,
    output out_pivot, out_pivot_wr, input out_pivot_full,
    output out_buff_size, out_buff_size_wr, input out_buff_size_full,
    output out_median_pos, out_median_pos_wr, input out_median_pos_full,
    output out_second_median_value, out_second_median_value_wr,
    input  out_second_median_value_full,
    output out_median, out_median_wr, input out_median_full
  );
endinterface

// File: rtl/median_partition_actor.sv
// median_partition_actor: one partition step of the median dataflow chain.
// Pops a header (pivot, size, rank, second value), buffers up to BUFF_SIZE
// pixels while classifying them against the pivot, then either emits the
// pivot as the median (rank lands in the "equal" class) or forwards the
// selected less/greater sub-partition with a fresh header to the next stage.
// Optional feature: define MEDIAN_PARTITION_ITER_CNT_EN to add the 8-bit
// out_iter port counting forwarded partitions since the last median result.
module median_partition_actor #(
  parameter int         BUFF_SIZE     = 8,
  parameter int         BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic [7:0] DEFAULT_PIVOT = 8'd127
) (
  input logic clock,
  input logic reset,
  median_partition_if.slave bus
`ifdef MEDIAN_PARTITION_ITER_CNT_EN
  ,
  output logic [7:0] out_iter
`endif
);

  localparam int IDX_W = $clog2(BUFF_SIZE);

  typedef logic [BUFF_SIZE_BIT-1:0] cnt_t;
  localparam cnt_t MAX_SIZE = cnt_t'(BUFF_SIZE);
  localparam cnt_t ONE      = cnt_t'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DECIDE,
    S_EMIT_HDR,
    S_EMIT_PX,
    S_RESULT
  } state_t;

  typedef enum logic [1:0] {
    CLS_LT,
    CLS_EQ,
    CLS_GT
  } cls_t;

  function automatic cls_t classify(input logic [7:0] px, input logic [7:0] pv);
    if (px < pv)  return CLS_LT;
    if (px == pv) return CLS_EQ;
    return CLS_GT;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_run_en;
  logic [7:0] r_buf [BUFF_SIZE];
  logic [7:0] r_pivot;
  logic [7:0] r_second;
  cnt_t       r_size;
  cnt_t       r_pos;
  cnt_t       r_idx;
  cnt_t       r_scan;
  cnt_t       r_lt_cnt;
  cnt_t       r_eq_cnt;
  cnt_t       r_gt_cnt;
  logic [7:0] r_first_lt;
  logic [7:0] r_first_gt;
  cls_t       r_sel;
  logic [3:0] r_hdr_done;
  logic [7:0] r_out_pivot;
  cnt_t       r_out_size;
  cnt_t       r_out_pos;
  logic [7:0] r_out_second;
  logic [7:0] r_out_median;

  logic       w_hdr_avail;
  logic       w_hdr_pop;
  cnt_t       w_size_clamped;
  cnt_t       w_pos_clamped;
  logic       w_px_rd;
  logic       w_px_pop;
  cls_t       w_px_cls;
  logic       w_fill_last;
  cnt_t       w_lt_eq;
  logic       w_sel_lt;
  logic       w_sel_gt;
  logic [7:0] w_scan_px;
  logic       w_scan_hit;
  logic       w_scan_adv;
  logic       w_scan_last;
  logic       w_px_wr;
  logic [3:0] w_hdr_full;
  logic [3:0] w_hdr_wr;
  logic [3:0] w_hdr_done_nxt;
  logic       w_median_wr;

  // Header pop and clamping of size/rank to the buffer depth
  assign w_hdr_avail = !bus.in_pivot_empty && !bus.in_buff_size_empty &&
                       !bus.in_median_pos_empty && !bus.in_second_median_value_empty;
  assign w_hdr_pop   = r_run_en && (r_state == S_IDLE) && w_hdr_avail;
  assign w_size_clamped = (bus.in_buff_size > MAX_SIZE) ? MAX_SIZE : bus.in_buff_size;
  assign w_pos_clamped  = (w_size_clamped == '0) ? '0 :
                          (bus.in_median_pos >= w_size_clamped) ? (w_size_clamped - ONE) :
                          bus.in_median_pos;

  // Pixel fill
  assign w_px_rd     = (r_state == S_FILL) && (r_idx < r_size);
  assign w_px_pop    = w_px_rd && !bus.in_px_empty;
  assign w_px_cls    = classify(bus.in_px, r_pivot);
  assign w_fill_last = w_px_pop && ((r_idx + ONE) == r_size);

  // Partition selection; a GT choice guarantees gt_cnt >= 1 because pos <= size-1
  assign w_lt_eq  = r_lt_cnt + r_eq_cnt;
  assign w_sel_lt = (r_pos < r_lt_cnt);
  assign w_sel_gt = !w_sel_lt && (r_pos >= w_lt_eq);

  // Sub-partition scan over the buffer in arrival order
  assign w_scan_px   = r_buf[r_scan[IDX_W-1:0]];
  assign w_scan_hit  = (classify(w_scan_px, r_pivot) == r_sel);
  assign w_px_wr     = (r_state == S_EMIT_PX) && w_scan_hit && !bus.out_px_full;
  assign w_scan_adv  = (r_state == S_EMIT_PX) && (!w_scan_hit || !bus.out_px_full);
  assign w_scan_last = w_scan_adv && ((r_scan + ONE) == r_size);

  // Header tokens leave independently; bit order {second, pos, size, pivot}
  assign w_hdr_full = {bus.out_second_median_value_full, bus.out_median_pos_full,
                       bus.out_buff_size_full, bus.out_pivot_full};
  assign w_hdr_wr   = (r_state == S_EMIT_HDR) ? (~r_hdr_done & ~w_hdr_full) : 4'b0000;
  assign w_hdr_done_nxt = r_hdr_done | w_hdr_wr;

  assign w_median_wr = (r_state == S_RESULT) && !bus.out_median_full;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state elements use non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_hdr_pop) w_state_nxt = (w_size_clamped == '0) ? S_RESULT : S_FILL;
      S_FILL:     if (w_fill_last) w_state_nxt = S_DECIDE;
      S_DECIDE:   w_state_nxt = (w_sel_lt || w_sel_gt) ? S_EMIT_HDR : S_RESULT;
      S_EMIT_HDR: if (&w_hdr_done_nxt) w_state_nxt = S_EMIT_PX;
      S_EMIT_PX:  if (w_scan_last) w_state_nxt = S_IDLE;
      S_RESULT:   if (w_median_wr) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Header capture, classification counters, decision and output token registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_en     <= 1'b0;
      r_pivot      <= '0;
      r_second     <= '0;
      r_size       <= '0;
      r_pos        <= '0;
      r_idx        <= '0;
      r_scan       <= '0;
      r_lt_cnt     <= '0;
      r_eq_cnt     <= '0;
      r_gt_cnt     <= '0;
      r_first_lt   <= '0;
      r_first_gt   <= '0;
      r_sel        <= CLS_LT;
      r_hdr_done   <= '0;
      r_out_pivot  <= DEFAULT_PIVOT;
      r_out_size   <= '0;
      r_out_pos    <= '0;
      r_out_second <= '0;
      r_out_median <= DEFAULT_PIVOT;
    end else begin
      r_run_en <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_hdr_pop) begin
            r_pivot    <= bus.in_pivot;
            r_second   <= bus.in_second_median_value;
            r_size     <= w_size_clamped;
            r_pos      <= w_pos_clamped;
            r_idx      <= '0;
            r_lt_cnt   <= '0;
            r_eq_cnt   <= '0;
            r_gt_cnt   <= '0;
            r_first_lt <= '0;
            r_first_gt <= '0;
            if (w_size_clamped == '0) r_out_median <= bus.in_pivot;
          end
        end
        S_FILL: begin
          if (w_px_pop) begin
            r_idx <= r_idx + ONE;
            unique case (w_px_cls)
              CLS_LT: begin
                if (r_lt_cnt == '0) r_first_lt <= bus.in_px;
                r_lt_cnt <= r_lt_cnt + ONE;
              end
              CLS_EQ: r_eq_cnt <= r_eq_cnt + ONE;
              default: begin
                if (r_gt_cnt == '0) r_first_gt <= bus.in_px;
                r_gt_cnt <= r_gt_cnt + ONE;
              end
            endcase
          end
        end
        S_DECIDE: begin
          r_hdr_done <= '0;
          r_scan     <= '0;
          if (w_sel_lt) begin
            r_sel        <= CLS_LT;
            r_out_pivot  <= r_first_lt;
            r_out_size   <= r_lt_cnt;
            r_out_pos    <= r_pos;
            r_out_second <= r_second;
          end else if (w_sel_gt) begin
            r_sel        <= CLS_GT;
            r_out_pivot  <= r_first_gt;
            r_out_size   <= r_gt_cnt;
            r_out_pos    <= r_pos - w_lt_eq;
            r_out_second <= r_second;
          end else begin
            r_out_median <= r_pivot;
          end
        end
        S_EMIT_HDR: r_hdr_done <= w_hdr_done_nxt;
        S_EMIT_PX:  if (w_scan_adv) r_scan <= r_scan + ONE;
        default: ;
      endcase
    end
  end

  // Pixel buffer write
  // NOTE: the buffer has no reset; every entry is written in FILL before the
  // scan can read it, and out_px is forced to zero outside EMIT_PX.
  always_ff @(posedge clock) begin
    if (w_px_pop) r_buf[r_idx[IDX_W-1:0]] <= bus.in_px;
  end

`ifdef MEDIAN_PARTITION_ITER_CNT_EN
  logic [7:0] r_iter;

  // Forwarded-partition counter, cleared by a median result, saturating at 255
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iter <= '0;
    end else if (w_median_wr) begin
      r_iter <= '0;
    end else if (w_scan_last && (r_iter != 8'hFF)) begin
      r_iter <= r_iter + 8'd1;
    end
  end

  assign out_iter = r_iter;
`endif

  assign bus.in_pivot_rd               = w_hdr_pop;
  assign bus.in_buff_size_rd           = w_hdr_pop;
  assign bus.in_median_pos_rd          = w_hdr_pop;
  assign bus.in_second_median_value_rd = w_hdr_pop;
  assign bus.in_px_rd                  = w_px_rd;

  assign bus.out_px                     = (r_state == S_EMIT_PX) ? w_scan_px : 8'h00;
  assign bus.out_px_wr                  = w_px_wr;
  assign bus.out_pivot                  = r_out_pivot;
  assign bus.out_pivot_wr               = w_hdr_wr[0];
  assign bus.out_buff_size              = r_out_size;
  assign bus.out_buff_size_wr           = w_hdr_wr[1];
  assign bus.out_median_pos             = r_out_pos;
  assign bus.out_median_pos_wr          = w_hdr_wr[2];
  assign bus.out_second_median_value    = r_out_second;
  assign bus.out_second_median_value_wr = w_hdr_wr[3];
  assign bus.out_median                 = r_out_median;
  assign bus.out_median_wr              = w_median_wr;

endmodule
